// File: rtl/ep_tone_gen_multi.sv
// ep_tone_gen_multi: NUM_CH independent square-wave tone channels (C5..B5, octave shift, rest).
// Define EP_TONE_DUTY_EN to add a per-channel duty-cycle select input.
module ep_tone_gen_multi #(
   parameter int CLK_HZ = 1000000,
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
) (
   input  logic                        clk1M,
   input  logic                        rst_n,
   input  logic [4*NUM_CH-1:0]         note,
   input  logic [2*NUM_CH-1:0]         oct,
`ifdef EP_TONE_DUTY_EN
   input  logic [2*NUM_CH-1:0]         duty,
`endif
   output logic [NUM_CH-1:0]           out,
   output logic [NUM_CH-1:0]           tick,
   output logic [$clog2(NUM_CH+1)-1:0] mix
);
   localparam int MIX_W = $clog2(NUM_CH+1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

   if (64'(2 * CLK_HZ / 32'd523) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
      $error("CNT_W too narrow for the low-octave C period at CLK_HZ");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_num_ch_check
      $error("NUM_CH must be in 1..8");
   end

   // Period in clocks for a note/octave pair; all divisions are by constants.
   function automatic logic [CNT_W-1:0] period_of(input logic [3:0] n, input logic [1:0] o);
      logic [CNT_W-1:0] pm;
      case (n)
         4'd0:    pm = CNT_W'(CLK_HZ / 32'd523);
         4'd1:    pm = CNT_W'(CLK_HZ / 32'd554);
         4'd2:    pm = CNT_W'(CLK_HZ / 32'd587);
         4'd3:    pm = CNT_W'(CLK_HZ / 32'd622);
         4'd4:    pm = CNT_W'(CLK_HZ / 32'd659);
         4'd5:    pm = CNT_W'(CLK_HZ / 32'd698);
         4'd6:    pm = CNT_W'(CLK_HZ / 32'd740);
         4'd7:    pm = CNT_W'(CLK_HZ / 32'd784);
         4'd8:    pm = CNT_W'(CLK_HZ / 32'd831);
         4'd9:    pm = CNT_W'(CLK_HZ / 32'd880);
         4'd10:   pm = CNT_W'(CLK_HZ / 32'd932);
         4'd11:   pm = CNT_W'(CLK_HZ / 32'd988);
         default: pm = '0;
      endcase
      case (o)
         2'd0:    period_of = pm << 1'b1;
         2'd1:    period_of = pm;
         2'd2:    period_of = pm >> 1'b1;
         default: period_of = '0;
      endcase
   endfunction

`ifdef EP_TONE_DUTY_EN
   // Low portion of a period for the selected duty code.
   function automatic logic [CNT_W-1:0] low_of(input logic [CNT_W-1:0] p, input logic [1:0] d);
      case (d)
         2'd0:    low_of = p - (p >> 2'd1);
         2'd1:    low_of = p - (p >> 2'd2);
         2'd2:    low_of = p - (p >> 2'd3);
         2'd3:    low_of = p >> 2'd2;
         default: low_of = p >> 2'd1;
      endcase
   endfunction
`endif

   logic [NUM_CH-1:0] out_next_all_s;
   logic [MIX_W-1:0]  mix_next_s;
   logic [MIX_W-1:0]  mix_r;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ch_state_t        state_r, state_next_s;
      logic [CNT_W-1:0] cnt_r, cnt_next_s, per_r, per_next_s, low_r, low_next_s;
      logic [CNT_W-1:0] p_in_s, l_in_s;
      logic             valid_s, wrap_s, out_r, out_next_s, tick_r, tick_next_s;

      // Undefined or X codes make valid_s non-true, which every branch below treats as rest.
      assign valid_s = (note[4*c +: 4] < 4'd12) && (oct[2*c +: 2] != 2'd3);
      assign p_in_s  = period_of(note[4*c +: 4], oct[2*c +: 2]);
`ifdef EP_TONE_DUTY_EN
      assign l_in_s  = low_of(p_in_s, duty[2*c +: 2]);
`else
      assign l_in_s  = p_in_s >> 1'b1;
`endif
      assign wrap_s  = (cnt_r == per_r - ONE);

      // Channel state and datapath registers; reset aborts any running period.
      always_ff @(posedge clk1M or negedge rst_n) begin
         if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            per_r   <= '0;
            low_r   <= '0;
            out_r   <= 1'b0;
            tick_r  <= 1'b0;
         end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            per_r   <= per_next_s;
            low_r   <= low_next_s;
            out_r   <= out_next_s;
            tick_r  <= tick_next_s;
         end
      end

      // Next state: note/octave is latched only at start or at a period wrap.
      always_comb begin
         state_next_s = state_r;
         cnt_next_s   = cnt_r;
         per_next_s   = per_r;
         low_next_s   = low_r;
         case (state_r)
            IDLE: begin
               if (valid_s) begin
                  state_next_s = RUN;
                  cnt_next_s   = '0;
                  per_next_s   = p_in_s;
                  low_next_s   = l_in_s;
               end else begin
                  cnt_next_s   = '0;
               end
            end
            RUN: begin
               if (valid_s) begin
                  if (wrap_s) begin
                     cnt_next_s = '0;
                     per_next_s = p_in_s;
                     low_next_s = l_in_s;
                  end else begin
                     cnt_next_s = cnt_r + ONE;
                  end
               end else begin
                  state_next_s = IDLE;
                  cnt_next_s   = '0;
               end
            end
            default: begin
               state_next_s = IDLE;
               cnt_next_s   = '0;
            end
         endcase
      end

      // Output next values, registered alongside the counter.
      always_comb begin
         tick_next_s = 1'b0;
         out_next_s  = 1'b0;
         if ((state_r == RUN) && valid_s && wrap_s) begin
            tick_next_s = 1'b1;
         end else begin
            tick_next_s = 1'b0;
         end
         if ((state_next_s == RUN) && (cnt_next_s >= low_next_s)) begin
            out_next_s = 1'b1;
         end else begin
            out_next_s = 1'b0;
         end
      end

      assign out_next_all_s[c] = out_next_s;
      assign out[c]            = out_r;
      assign tick[c]           = tick_r;
   end

   // Population count of the channels' next outputs.
   always_comb begin
      mix_next_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mix_next_s = mix_next_s + MIX_W'(out_next_all_s[i]);
      end
   end

   // Mix register, aligned with the per-channel out registers.
   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) begin
         mix_r <= '0;
      end else begin
         mix_r <= mix_next_s;
      end
   end

   assign mix = mix_r;
endmodule
